dp_job_scheduler: RTL
=====================

Name: dp_job_scheduler

Overview:
- Shares one compute datapath (8-bit x in, 8-bit y out, 2-bit mode select, start pulse, busy flag) between two requesters.
- Arbitrates requests round-robin, latches the winner's operand and mode, and pulses the datapath start.
- Waits for the busy handshake, captures the result, and returns it with a done/err pulse.
- Enforces timeouts and keeps job/error counters for debug visibility.

Parameters:
- ACK_TIMEOUT, 8, max cycles in WAIT_BUSY for dp_busy to rise before aborting.
- RUN_TIMEOUT, 32, max cycles in RUN for dp_busy to fall before aborting.
- CW, 6, timeout counter width; must hold max(ACK_TIMEOUT, RUN_TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  2  per-requester level request; held until own done pulse.
- x0  in  8  requester 0 operand.
- x1  in  8  requester 1 operand.
- mode0  in  2  requester 0 datapath mode.
- mode1  in  2  requester 1 mode.
- gnt  out  2  one-hot, 1-cycle pulse when a job is accepted.
- done  out  2  one-hot, 1-cycle pulse when a job completes.
- err  out  1  valid with done; 1 = aborted/rejected.
- result  out  8  job result, valid with done; holds until next done.
- dp_x  out  8  operand to datapath.
- dp_on  out  2  mode to datapath; 0 when idle.
- dp_start  out  1  1-cycle start pulse.
- dp_busy  in  1  datapath busy flag.
- dp_y  in  8  datapath result.
- state  out  3  current FSM state (debug).
- jobs_done  out  8  count of successful jobs, wraps 255->0.
- err_cnt  out  4  count of err completions, saturates at 15.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, all outputs 0 (gnt, done, err, result, dp_x, dp_on, dp_start, jobs_done, err_cnt).
- Reset mid-job: all state is dropped immediately. No done pulse is issued. dp_on=0 forces the datapath off.
- State encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, RUN=3, DONE=4.
- IDLE:
  - Only one requester active: it wins.
  - Both requesters active: the winner is rr (rr=0 -> requester 0).
  - Winner with mode!=0: latch id, x, mode; gnt[id]=1 that cycle; next state ISSUE.
  - Winner with mode==0: gnt[id]=1; next state DONE with err=1 and result=0. The datapath is not touched.
- ISSUE: dp_x and dp_on driven from the latch, dp_start=1 for exactly this cycle. Timeout counter cleared. Next state WAIT_BUSY.
- WAIT_BUSY:
  - dp_busy=1 -> RUN, counter cleared.
  - Otherwise the counter increments. At counter==ACK_TIMEOUT-1 -> DONE with err=1.
- RUN:
  - dp_busy=0 -> capture dp_y into the result register -> DONE, err=0.
  - Otherwise the counter increments. At counter==RUN_TIMEOUT-1 -> DONE with err=1, result=0.
- dp_x and dp_on stay stable from ISSUE through RUN. dp_on returns to 0 on entry to DONE.
- DONE: done[id]=1, err and result valid for this single cycle. Next state IDLE.
  - rr <= ~id.
  - jobs_done increments if err=0.
  - err_cnt increments (saturating) if err=1.
- Minimum latency, req to done: 5 cycles (IDLE, ISSUE, WAIT_BUSY, RUN, DONE), given busy rises the cycle after start and falls the next.
- A new grant is possible in the cycle after DONE.
- Deasserting req before grant: the request is not served. Deasserting req after grant: the job still runs to done.
- Requesters must deassert req or change operands on the done cycle. A req still high in IDLE is treated as a new job.
- Inputs x*/mode* are sampled only in the grant cycle.
- dp_busy already 1 when entering WAIT_BUSY: transition to RUN on the next edge, with no error.

Test Plan:
- Single job: rst low for 4 cycles, then req=01, x0=5, mode0=3; datapath model raises busy 1 cycle after start, holds 2 cycles, y=10 -> gnt=01 once, dp_start a 1-cycle pulse, dp_x=5, dp_on=3, done=01 with result=10 and err=0, jobs_done=1.
- Contention: req=11 held continuously, x0=1, x1=2 -> grants alternate 01, 10, 01; results tagged correctly; rr toggles after each DONE.
- Ack timeout: dp_busy tied 0, req=10, mode1=1 -> done=10, err=1, result=0 exactly ACK_TIMEOUT cycles after leaving ISSUE; err_cnt=1; dp_on=0 afterwards.
- Run timeout and saturation: dp_busy tied 1, 16 jobs -> each aborts after RUN_TIMEOUT cycles; err_cnt=15 (saturated); jobs_done=0.
- Mode 0 reject: req=01, mode0=0 -> gnt and done pulses, err=1, dp_start never asserted.
- Async reset mid-RUN: drop rst while busy=1 -> all outputs 0 immediately without a clock edge, no done pulse; after release, a fresh req completes normally.

Source files
------------

// File: rtl/dp_job_scheduler_if.sv
// Requester / datapath bundle for dp_job_scheduler.
//   slave  modport : the scheduler (consumes requests and datapath status,
//                    drives grants, completions and datapath controls).
//   master modport : the environment (requesters plus datapath).
// Signals:
//   req[1:0]      per-requester level request
//   x0, x1        requester operands (8 bit)
//   mode0, mode1  requester datapath modes (2 bit)
//   gnt[1:0]      one-hot grant pulse
//   done[1:0]     one-hot completion pulse
//   err           abort/reject flag, valid with done
//   result        job result, valid with done, held until next done
//   dp_x, dp_on   operand and mode towards the datapath
//   dp_start      datapath start pulse
//   dp_busy       datapath busy flag
//   dp_y          datapath result
interface dp_job_scheduler_if;
   logic [1:0] req;
   logic [7:0] x0;
   logic [7:0] x1;
   logic [1:0] mode0;
   logic [1:0] mode1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       err;
   logic [7:0] result;
   logic [7:0] dp_x;
   logic [1:0] dp_on;
   logic       dp_start;
   logic       dp_busy;
   logic [7:0] dp_y;

   modport slave (
      input  req, x0, x1, mode0, mode1, dp_busy, dp_y,
      output gnt, done, err, result, dp_x, dp_on, dp_start
   );

   modport master (
      output req, x0, x1, mode0, mode1, dp_busy, dp_y,
      input  gnt, done, err, result, dp_x, dp_on, dp_start
   );
endinterface

// File: rtl/dp_job_scheduler.sv
// Shares one compute datapath between two requesters. Requests are
// arbitrated round-robin; the winner's operand and mode are latched, the
// datapath is started, its busy handshake is followed with ack/run
// timeouts, and the result is returned with a one-hot done pulse.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        dp_job_scheduler_if.slave (requester and datapath signals)
//   state      current FSM state (debug)
//   jobs_done  successful job count, wraps
//   err_cnt    error completion count, saturates at 15
module dp_job_scheduler #(
   parameter int unsigned ACK_TIMEOUT = 8,
   parameter int unsigned RUN_TIMEOUT = 32,
   parameter int unsigned CW          = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   dp_job_scheduler_if.slave      bus,
   output logic [2:0]             state,
   output logic [7:0]             jobs_done,
   output logic [3:0]             err_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      RUN       = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_id;
   logic            r_rr;
   logic            r_err;
   logic [7:0]      r_x;
   logic [1:0]      r_mode;
   logic [7:0]      r_result;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_jobs;
   logic [3:0]      r_errcnt;

   logic            w_any;
   logic            w_sel_id;
   logic [1:0]      w_sel_mode;
   logic [7:0]      w_sel_x;
   logic            w_grant;
   logic            w_ld_job;
   logic            w_cnt_clr;
   logic            w_cnt_inc;
   logic            w_fin;
   logic            w_fin_err;
   logic [7:0]      w_fin_res;
   logic            w_active;

   // Gated by rst so a request held during reset cannot show a grant.
   assign w_any      = rst & (|bus.req);
   assign w_sel_id   = (bus.req == 2'b11) ? r_rr : bus.req[1];
   assign w_sel_mode = w_sel_id ? bus.mode1 : bus.mode0;
   assign w_sel_x    = w_sel_id ? bus.x1 : bus.x0;

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_ld_job  = 1'b0;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_fin     = 1'b0;
      w_fin_err = 1'b0;
      w_fin_res = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant = 1'b1;
               if (w_sel_mode != 2'd0) begin
                  w_ld_job = 1'b1;
                  w_next   = ISSUE;
               end else begin
                  // Mode 0 is rejected without touching the datapath.
                  w_fin     = 1'b1;
                  w_fin_err = 1'b1;
                  w_next    = DONE;
               end
            end
         end
         ISSUE: begin
            w_cnt_clr = 1'b1;
            w_next    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.dp_busy) begin
               w_cnt_clr = 1'b1;
               w_next    = RUN;
            end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
               w_next    = DONE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         RUN: begin
            if (!bus.dp_busy) begin
               w_fin     = 1'b1;
               w_fin_res = bus.dp_y;
               w_next    = DONE;
            end else if (r_cnt == CW'(RUN_TIMEOUT - 1)) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
               w_next    = DONE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_id     <= 1'b0;
         r_rr     <= 1'b0;
         r_err    <= 1'b0;
         r_x      <= '0;
         r_mode   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_jobs   <= '0;
         r_errcnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) r_id <= w_sel_id;
         if (w_ld_job) begin
            r_x    <= w_sel_x;
            r_mode <= w_sel_mode;
         end
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
         if (w_fin) begin
            r_err    <= w_fin_err;
            r_result <= w_fin_res;
         end
         if (r_state == DONE) begin
            r_rr <= ~r_id;
            if (r_err) begin
               if (r_errcnt != '1) r_errcnt <= r_errcnt + 4'd1;
            end else begin
               r_jobs <= r_jobs + 8'd1;
            end
         end
      end
   end

   assign w_active     = (r_state == ISSUE) || (r_state == WAIT_BUSY) || (r_state == RUN);
   assign bus.gnt      = (r_state == IDLE && w_any) ? (w_sel_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.done     = (r_state == DONE) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.err      = (r_state == DONE) & r_err;
   assign bus.result   = r_result;
   assign bus.dp_x     = w_active ? r_x : 8'd0;
   assign bus.dp_on    = w_active ? r_mode : 2'd0;
   assign bus.dp_start = (r_state == ISSUE);
   assign state        = r_state;
   assign jobs_done    = r_jobs;
   assign err_cnt      = r_errcnt;

endmodule
